// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage -- instruction-fetch stage of CPU_Pipelined
//
// Holds the PC and a word-addressed instruction memory. It decodes the fetched
// word early so jumps (always) and beq/bne (when predicting taken) can redirect
// the fetch stream. It also holds the IF/ID pipeline register that feeds decode.
//
// Parameters:
//   IM_DEPTH  instruction memory depth in 32-bit words
//   RESET_PC  byte address loaded into PC on reset (word aligned)
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   predict_mode    00 not taken, 01 taken, 10 delay slot, 11 same as 00
//   stall           hazard unit request to hold PC and IF/ID
//   ex_redirect     EX resolved a mispredict; flush IF/ID and load ex_redirect_pc
//   ex_redirect_pc  corrected next PC (low two bits ignored)
//   PC, IFIR        current fetch address and the instruction read there
//   IDIR, id_pc4    IF/ID instruction and its PC+4
//   id_pred_taken   IF redirected on this branch
//   id_valid        IF/ID holds a real instruction
//
// Optional feature (macro FETCH_STATS_EN): adds saturating counters
//   stat_fetched, stat_flushed and stat_stalled.
// ----------------------------------------------------------------------------

// Read-only instruction memory. The bench preloads it hierarchically through
// the "memory" array. Addresses beyond the array read as zero (nop).
module fetch_imem #(
    parameter int IM_DEPTH = 256
) (
    input  logic [29:0] word_addr,
    output logic [31:0] data
);
    localparam int AW = (IM_DEPTH > 1) ? $clog2(IM_DEPTH) : 1;

    logic [31:0] memory [0:IM_DEPTH-1];

    always_comb begin
        data = 32'h0;
        if ({2'b00, word_addr} < 32'(IM_DEPTH))
            data = memory[word_addr[AW-1:0]];
    end
endmodule

module fetch_stage #(
    parameter int          IM_DEPTH = 256,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  predict_mode,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    output logic [31:0] PC,
    output logic [31:0] IFIR,
    output logic [31:0] IDIR,
    output logic [31:0] id_pc4,
    output logic        id_pred_taken,
    output logic        id_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed,
    output logic [31:0] stat_stalled
`endif
);
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    logic [5:0]  opcode;
    logic        is_branch;
    logic        is_jump;
    logic        take_branch;

    fetch_imem #(.IM_DEPTH(IM_DEPTH)) MYIM (
        .word_addr (PC[31:2]),
        .data      (IFIR)
    );

    // Early decode of the fetched word. All arithmetic wraps modulo 2^32.
    // Only beq/bne predicted taken flag id_pred_taken. Jumps are unconditional
    // and never need an EX check.
    always_comb begin
        opcode        = IFIR[31:26];
        pc_plus4      = PC + 32'd4;
        branch_target = pc_plus4 + {{14{IFIR[15]}}, IFIR[15:0], 2'b00};
        jump_target   = {pc_plus4[31:28], IFIR[25:0], 2'b00};
        is_branch     = (opcode == OP_BEQ) || (opcode == OP_BNE);
        is_jump       = (opcode == OP_J);
        take_branch   = is_branch && (predict_mode == 2'b01);
        next_pc       = pc_plus4;
        if (is_jump)
            next_pc = jump_target;
        else if (take_branch)
            next_pc = branch_target;
    end

    // PC and IF/ID register. An EX redirect flushes IF/ID even while stalled.
    // id_pc4 is left untouched by a flush because the bubble never uses it.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC            <= RESET_PC;
            IDIR          <= 32'h0;
            id_pc4        <= 32'h0;
            id_pred_taken <= 1'b0;
            id_valid      <= 1'b0;
        end else if (ex_redirect) begin
            PC            <= ex_redirect_pc & ~32'h3;
            IDIR          <= 32'h0;
            id_pred_taken <= 1'b0;
            id_valid      <= 1'b0;
        end else if (!stall) begin
            PC            <= next_pc;
            IDIR          <= IFIR;
            id_pc4        <= pc_plus4;
            id_pred_taken <= take_branch;
            id_valid      <= 1'b1;
        end
    end

`ifdef FETCH_STATS_EN
    // Exactly one counter advances per non-reset edge. Their sum therefore
    // tracks the number of cycles since reset release. Each counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= 32'h0;
            stat_flushed <= 32'h0;
            stat_stalled <= 32'h0;
        end else if (ex_redirect) begin
            if (stat_flushed != 32'hFFFF_FFFF)
                stat_flushed <= stat_flushed + 32'd1;
        end else if (stall) begin
            if (stat_stalled != 32'hFFFF_FFFF)
                stat_stalled <= stat_stalled + 32'd1;
        end else begin
            if (stat_fetched != 32'hFFFF_FFFF)
                stat_fetched <= stat_fetched + 32'd1;
        end
    end
`endif
endmodule
